one_bit_fsm_dec: RTL and testbench

ONE_BIT_FSM_DEC -- requirements
Module: one_bit_fsm_dec

---
 rtl/one_bit_fsm_dec.sv | 175 +++++++++++++++++
 tb/tb_one_bit_fsm_dec.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/one_bit_fsm_dec.sv
// -----------------------------------------------------------------------------
// one_bit_fsm_dec
// Control FSM for the bit-serial authenticated decryption datapath. Sequences
// the init, associated-data, ciphertext and finalisation phases, kicks the
// permutation, and (optionally) performs a 128-cycle bit-serial tag check.
//
// Ports:
//   clk                input  rising-edge clock
//   rst                input  asynchronous active-high reset
//   start_decryption   input  start request, honoured only in IDLE
//   iteration_done     input  round counter completion flag
//   count_done         input  bit counter completion flag
//   tag_bit_eq         input  computed tag bit == received tag bit (TAG_CHK)
//   state_sel_padding  output [2:0] datapath state-mux select
//   start_permutation  output permutation kick
//   rst_d_counter      output active-low datapath counter reset
//   iteration          output [3:0] round count for the current phase
//   decryption_done    output one-cycle completion pulse
//   auth_fail          output registered tag mismatch flag
//
// Configuration macro:
//   DEC_TAG_CHECK_EN   defined: TAG_CHK state, tag counter and auth_fail active
//                      undefined: F_F advance ends the operation, auth_fail = 0
// -----------------------------------------------------------------------------
module one_bit_fsm_dec (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_decryption,
  input  logic       iteration_done,
  input  logic       count_done,
  input  logic       tag_bit_eq,
  output logic [2:0] state_sel_padding,
  output logic       start_permutation,
  output logic       rst_d_counter,
  output logic [3:0] iteration,
  output logic       decryption_done,
  output logic       auth_fail
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] S_I     = 4'd1;
  localparam logic [3:0] F_I     = 4'd2;
  localparam logic [3:0] S_A     = 4'd3;
  localparam logic [3:0] F_A     = 4'd4;
  localparam logic [3:0] S_C     = 4'd5;
  localparam logic [3:0] F_C     = 4'd6;
  localparam logic [3:0] FINAL   = 4'd7;
  localparam logic [3:0] F_F     = 4'd8;
  localparam logic [3:0] TAG_CHK = 4'd9;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       w_advance;
  logic       w_tag_last;

  assign w_advance = count_done & iteration_done;

`ifdef DEC_TAG_CHECK_EN
  logic [6:0] r_tag_cnt;
  logic       r_mismatch;
  logic       r_auth_fail;

  assign w_tag_last = (r_tag_cnt == 7'd127);
  assign auth_fail  = r_auth_fail;
`else
  logic w_unused_tag;

  assign w_tag_last   = 1'b0;
  assign w_unused_tag = tag_bit_eq;
  assign auth_fail    = 1'b0;
`endif

  // Next state and strobes. Phases occupy consecutive codes, so a phase
  // advance is simply r_state + 1.
  always_comb begin
    w_next_state      = r_state;
    start_permutation = 1'b0;
    rst_d_counter     = 1'b1;
    decryption_done   = 1'b0;
    if (rst) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_decryption) begin
            w_next_state      = S_I;
            start_permutation = 1'b1;
            rst_d_counter     = 1'b0;
          end
        end
        S_I, F_I, S_A, F_A, S_C, F_C, FINAL: begin
          if (w_advance) begin
            w_next_state  = r_state + 4'd1;
            rst_d_counter = 1'b0;
          end
        end
        F_F: begin
          start_permutation = 1'b1;
          if (w_advance) begin
            rst_d_counter = 1'b0;
`ifdef DEC_TAG_CHECK_EN
            w_next_state  = TAG_CHK;
`else
            w_next_state    = IDLE;
            decryption_done = 1'b1;
`endif
          end
        end
`ifdef DEC_TAG_CHECK_EN
        TAG_CHK: begin
          if (w_tag_last) begin
            w_next_state    = IDLE;
            decryption_done = 1'b1;
          end
        end
`endif
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Select and round count are decoded from the next state: in a holding
  // cycle that is the current state, in an advancing cycle it gives the
  // look-ahead values, and unused codes decode as IDLE.
  always_comb begin
    state_sel_padding = 3'b000;
    iteration         = 4'd11;
    case (w_next_state)
      F_I:     begin state_sel_padding = 3'b001; iteration = 4'd1; end
      S_A:     begin state_sel_padding = 3'b000; iteration = 4'd5; end
      F_A:     begin state_sel_padding = 3'b011; iteration = 4'd1; end
      S_C:     begin state_sel_padding = 3'b000; iteration = 4'd5; end
      F_C:     begin state_sel_padding = 3'b100; iteration = 4'd1; end
      F_F:     begin state_sel_padding = 3'b111; iteration = 4'd1; end
      default: begin state_sel_padding = 3'b000; iteration = 4'd11; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

`ifdef DEC_TAG_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_cnt   <= '0;
      r_mismatch  <= 1'b0;
      r_auth_fail <= 1'b0;
    end else begin
      if (r_state == IDLE && start_decryption) begin
        r_auth_fail <= 1'b0;
      end
      if (r_state == F_F && w_advance) begin
        r_tag_cnt  <= '0;
        r_mismatch <= 1'b0;
      end
      if (r_state == TAG_CHK) begin
        r_tag_cnt <= r_tag_cnt + 7'd1;
        if (!tag_bit_eq) begin
          r_mismatch <= 1'b1;
        end
        // Final bit is folded in directly since the latch has not seen it yet.
        if (w_tag_last) begin
          r_auth_fail <= r_mismatch | ~tag_bit_eq;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_one_bit_fsm_dec.sv
module tb_one_bit_fsm_dec;

  logic       clk;
  logic       rst;
  logic       start_decryption;
  logic       iteration_done;
  logic       count_done;
  logic       tag_bit_eq;
  logic [2:0] state_sel_padding;
  logic       start_permutation;
  logic       rst_d_counter;
  logic [3:0] iteration;
  logic       decryption_done;
  logic       auth_fail;

  int n_total = 0;
  int n_pass  = 0;

  one_bit_fsm_dec dut (
    .clk               (clk),
    .rst               (rst),
    .start_decryption  (start_decryption),
    .iteration_done    (iteration_done),
    .count_done        (count_done),
    .tag_bit_eq        (tag_bit_eq),
    .state_sel_padding (state_sel_padding),
    .start_permutation (start_permutation),
    .rst_d_counter     (rst_d_counter),
    .iteration         (iteration),
    .decryption_done   (decryption_done),
    .auth_fail         (auth_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       st, cd, id, teq;
    logic [2:0] sel;
    logic [3:0] it;
    logic       sp, rd, dn, af;
  } vec_t;

  function automatic vec_t mk(logic st, logic cd, logic id, logic teq,
                              logic [2:0] sel, logic [3:0] it,
                              logic sp, logic rd, logic dn, logic af);
    vec_t v;
    v.st = st; v.cd = cd; v.id = id; v.teq = teq;
    v.sel = sel; v.it = it; v.sp = sp; v.rd = rd; v.dn = dn; v.af = af;
    return v;
  endfunction

  task automatic chk(string nm, int got, int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic check_outs(string nm, logic [2:0] sel, logic [3:0] it,
                            logic sp, logic rd, logic dn, logic af);
    chk({nm, ".sel"},  int'(state_sel_padding), int'(sel));
    chk({nm, ".iter"}, int'(iteration),         int'(it));
    chk({nm, ".sp"},   int'(start_permutation), int'(sp));
    chk({nm, ".rd"},   int'(rst_d_counter),     int'(rd));
    chk({nm, ".done"}, int'(decryption_done),   int'(dn));
    chk({nm, ".af"},   int'(auth_fail),         int'(af));
  endtask

  task automatic drive(logic st, logic cd, logic id, logic teq);
    @(negedge clk);
    start_decryption = st;
    count_done       = cd;
    iteration_done   = id;
    tag_bit_eq       = teq;
  endtask

  task automatic cyc(string nm, vec_t v);
    drive(v.st, v.cd, v.id, v.teq);
    #1;
    check_outs(nm, v.sel, v.it, v.sp, v.rd, v.dn, v.af);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start_decryption = 1'b0; count_done = 1'b0; iteration_done = 1'b0;
    tag_bit_eq = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

`ifdef DEC_TAG_CHECK_EN
  // Runs a full decryption; bit k of the tag mismatches if k == bad.
  task automatic tag_run(string nm, int bad, logic exp_af);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (8) drive(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 128; k++) begin
      cyc($sformatf("%s.tag%0d", nm, k),
          mk(1'b0, 1'b0, 1'b0, (k != bad), 3'b000, 4'd11, 1'b0, 1'b1, (k == 127), 1'b0));
    end
    for (int k = 0; k < 3; k++) begin
      cyc($sformatf("%s.post%0d", nm, k),
          mk(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 4'd11, 1'b0, 1'b1, 1'b0, exp_af));
    end
  endtask
`endif

  vec_t vt[17];
  localparam logic FF_DONE =
`ifdef DEC_TAG_CHECK_EN
    1'b0;
`else
    1'b1;
`endif

  initial begin
    rst = 1'b1;
    start_decryption = 1'b0; count_done = 1'b0; iteration_done = 1'b0;
    tag_bit_eq = 1'b1;

    //          st  cd  id  teq  sel     it     sp  rd  dn       af
    vt[0]  = mk(0,  0,  0,  1,   3'd0,   4'd11, 0,  1,  0,       0); // idle hold
    vt[1]  = mk(0,  1,  1,  1,   3'd0,   4'd11, 0,  1,  0,       0); // flags w/o start
    vt[2]  = mk(1,  0,  0,  1,   3'd0,   4'd11, 1,  0,  0,       0); // start
    vt[3]  = mk(1,  1,  0,  1,   3'd0,   4'd11, 0,  1,  0,       0); // S_I, restart ignored
    vt[4]  = mk(0,  0,  1,  1,   3'd0,   4'd11, 0,  1,  0,       0); // S_I partial
    vt[5]  = mk(0,  1,  1,  1,   3'd1,   4'd1,  0,  0,  0,       0); // -> F_I
    vt[6]  = mk(0,  0,  0,  1,   3'd1,   4'd1,  0,  1,  0,       0); // F_I hold
    vt[7]  = mk(0,  1,  1,  1,   3'd0,   4'd5,  0,  0,  0,       0); // -> S_A
    vt[8]  = mk(0,  1,  0,  1,   3'd0,   4'd5,  0,  1,  0,       0); // S_A partial
    vt[9]  = mk(0,  1,  1,  1,   3'd3,   4'd1,  0,  0,  0,       0); // -> F_A
    vt[10] = mk(0,  1,  1,  1,   3'd0,   4'd5,  0,  0,  0,       0); // -> S_C
    vt[11] = mk(0,  0,  0,  1,   3'd0,   4'd5,  0,  1,  0,       0); // S_C hold
    vt[12] = mk(0,  1,  1,  1,   3'd4,   4'd1,  0,  0,  0,       0); // -> F_C
    vt[13] = mk(0,  1,  1,  1,   3'd0,   4'd11, 0,  0,  0,       0); // -> FINAL
    vt[14] = mk(0,  1,  1,  1,   3'd7,   4'd1,  0,  0,  0,       0); // -> F_F
    vt[15] = mk(0,  0,  0,  1,   3'd7,   4'd1,  1,  1,  0,       0); // F_F hold
    vt[16] = mk(0,  1,  1,  0,   3'd0,   4'd11, 1,  0,  FF_DONE, 0); // F_F advance

    // Outputs during reset are IDLE defaults even with start asserted.
    #2;
    start_decryption = 1'b1; count_done = 1'b1; iteration_done = 1'b1;
    #1;
    check_outs("reset", 3'd0, 4'd11, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 17; i++) cyc($sformatf("vec%0d", i), vt[i]);
`ifdef DEC_TAG_CHECK_EN
    for (int k = 0; k < 128; k++) begin
      cyc($sformatf("nom.tag%0d", k),
          mk(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 4'd11, 1'b0, 1'b1, (k == 127), 1'b0));
    end
`endif
    cyc("nom.idle", mk(0, 0, 0, 0, 3'd0, 4'd11, 0, 1, 0, 0));
    cyc("nom.idle2", mk(0, 1, 1, 0, 3'd0, 4'd11, 0, 1, 0, 0));

    // Partial flags in S_A for 10 cycles, then advance to F_A.
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++)
      cyc($sformatf("partial%0d", k), mk(0, 1, 0, 1, 3'd0, 4'd5, 0, 1, 0, 0));
    cyc("partial.adv", mk(0, 1, 1, 1, 3'd3, 4'd1, 0, 0, 0, 0));
    do_reset();

    // Reset asserted during F_C.
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) drive(1'b0, 1'b1, 1'b1, 1'b1);
    cyc("fc.hold", mk(0, 0, 0, 1, 3'd4, 4'd1, 0, 1, 0, 0));
    #1 rst = 1'b1;
    #1;
    check_outs("midrst", 3'd0, 4'd11, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    cyc("rst.nostart", mk(0, 1, 1, 1, 3'd0, 4'd11, 0, 1, 0, 0));
    cyc("rst.start",   mk(1, 0, 0, 1, 3'd0, 4'd11, 1, 0, 0, 0));
    cyc("rst.si_st",   mk(1, 0, 0, 1, 3'd0, 4'd11, 0, 1, 0, 0));
    cyc("rst.si_adv",  mk(0, 1, 1, 1, 3'd1, 4'd1,  0, 0, 0, 0));
    do_reset();

`ifdef DEC_TAG_CHECK_EN
    tag_run("bad37", 37, 1'b1);
    // auth_fail stays set until the next start is taken.
    cyc("clr.start", mk(1, 0, 0, 1, 3'd0, 4'd11, 1, 0, 0, 1));
    cyc("clr.si",    mk(0, 0, 0, 1, 3'd0, 4'd11, 0, 1, 0, 0));
    do_reset();
    tag_run("bad127", 127, 1'b1);
    do_reset();
    tag_run("good", -1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
